// File: rtl/scs8hd_cut_pkg.sv
// Shared types and sizes for the o311ai exhaustive vector sequencer.
package scs8hd_cut_pkg;

  localparam int unsigned VEC_W   = 5;
  localparam int unsigned NUM_VEC = 32;
  localparam int unsigned ERR_W   = 6;
  localparam int unsigned CNT_W   = 4;

  localparam logic [VEC_W-1:0] LAST_VEC = VEC_W'(NUM_VEC - 1);
  localparam logic [ERR_W-1:0] ERR_MAX  = ERR_W'(NUM_VEC);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    DRIVE  = 3'd1,
    SETTLE = 3'd2,
    SAMPLE = 3'd3,
    DONE   = 3'd4
  } state_t;

endpackage

// File: rtl/scs8hd_o311ai_golden.sv
// Reference model of the o311ai cell: y = !((a1|a2|a3) & b1 & c1).
module scs8hd_o311ai_golden (
  input  logic a1,
  input  logic a2,
  input  logic a3,
  input  logic b1,
  input  logic c1,
  output logic y_c
);

  assign y_c = ~((a1 | a2 | a3) & b1 & c1);

endmodule

// File: rtl/scs8hd_o311ai_vector_seq.sv
// Walks all 32 input vectors through an external o311ai cell and counts
// mismatches against the golden model.
module scs8hd_o311ai_vector_seq
  import scs8hd_cut_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  output logic             a1,
  output logic             a2,
  output logic             a3,
  output logic             b1,
  output logic             c1,
  input  logic             y_cut,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_cnt,
  output logic [VEC_W-1:0] first_fail
);

  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);

  state_t             state_q, state_d;
  logic [VEC_W-1:0]   vec_q, vec_d;
  logic [VEC_W-1:0]   stim_q, stim_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               busy_d, done_d, pass_d;
  logic [ERR_W-1:0]   err_d;
  logic [VEC_W-1:0]   ff_d;
  logic               y_exp;

  assign a1 = stim_q[0];
  assign a2 = stim_q[1];
  assign a3 = stim_q[2];
  assign b1 = stim_q[3];
  assign c1 = stim_q[4];

  scs8hd_o311ai_golden u_golden (
    .a1  (stim_q[0]),
    .a2  (stim_q[1]),
    .a3  (stim_q[2]),
    .b1  (stim_q[3]),
    .c1  (stim_q[4]),
    .y_c (y_exp)
  );

  // State and datapath registers; reset outranks abort and start.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      vec_q      <= '0;
      stim_q     <= '0;
      cnt_q      <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      err_cnt    <= '0;
      first_fail <= '0;
    end else begin
      state_q    <= state_d;
      vec_q      <= vec_d;
      stim_q     <= stim_d;
      cnt_q      <= cnt_d;
      busy       <= busy_d;
      done       <= done_d;
      pass       <= pass_d;
      err_cnt    <= err_d;
      first_fail <= ff_d;
    end
  end

  // Next-state and next-output logic; abort wins over every run transition.
  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    stim_d  = stim_q;
    cnt_d   = cnt_q;
    busy_d  = busy;
    done_d  = 1'b0;
    pass_d  = pass;
    err_d   = err_cnt;
    ff_d    = first_fail;

    if (state_q != IDLE && abort) begin
      state_d = IDLE;
      busy_d  = 1'b0;
      pass_d  = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start) begin
            state_d = DRIVE;
            vec_d   = '0;
            err_d   = '0;
            ff_d    = '0;
            pass_d  = 1'b0;
            busy_d  = 1'b1;
          end
        end
        DRIVE: begin
          stim_d  = vec_q;
          cnt_d   = '0;
          state_d = SETTLE;
        end
        SETTLE: begin
          if (cnt_q == SETTLE_LAST) begin
            state_d = SAMPLE;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        SAMPLE: begin
          if (y_cut != y_exp) begin
            if (err_cnt != ERR_MAX) err_d = err_cnt + ERR_W'(1);
            if (err_cnt == '0) ff_d = vec_q;
          end
          if (vec_q == LAST_VEC) begin
            state_d = DONE;
          end else begin
            vec_d   = vec_q + VEC_W'(1);
            state_d = DRIVE;
          end
        end
        DONE: begin
          done_d  = 1'b1;
          pass_d  = (err_cnt == '0);
          busy_d  = 1'b0;
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_scs8hd_o311ai_vector_seq.sv
// Scoreboard bench: runs queue their expected result, a monitor checks each done pulse.
module tb_scs8hd_o311ai_vector_seq;

  localparam int unsigned SETTLE  = 2;
  localparam int          RUN_LEN = 32 * (SETTLE + 2) + 1;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic       a1, a2, a3, b1, c1;
  logic       y_cut;
  logic       busy, done, pass;
  logic [5:0] err_cnt;
  logic [4:0] first_fail;

  int mode   = 0;   // 0 good cell, 1 stuck-at-1, 2 stuck-at-0
  int cyc    = 0;
  int checks = 0;
  int errors = 0;

  typedef struct {
    int done_cyc;
    int err;
    int ff;
    int pass;
  } exp_t;

  exp_t sbq[$];

  scs8hd_o311ai_vector_seq #(.SETTLE_CYCLES(SETTLE)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .abort      (abort),
    .a1         (a1),
    .a2         (a2),
    .a3         (a3),
    .b1         (b1),
    .c1         (c1),
    .y_cut      (y_cut),
    .busy       (busy),
    .done       (done),
    .pass       (pass),
    .err_cnt    (err_cnt),
    .first_fail (first_fail)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Cell under test: independent o311ai model or a stuck output.
  assign y_cut = (mode == 1) ? 1'b1 :
                 (mode == 2) ? 1'b0 :
                 ~((a1 | a2 | a3) & b1 & c1);

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int stim();
    return int'({c1, b1, a3, a2, a1});
  endfunction

  // Monitor: every done pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (rst_n && done) begin
      check("done_expected", int'(sbq.size() > 0), 1);
      if (sbq.size() > 0) begin
        exp_t e;
        e = sbq.pop_front();
        check("done_cycle", cyc, e.done_cyc);
        check("err_cnt", int'(err_cnt), e.err);
        if (e.err != 0) check("first_fail", int'(first_fail), e.ff);
        check("pass", int'(pass), e.pass);
        check("busy_at_done", int'(busy), 0);
      end
    end
  end

  task automatic start_run(input int m, input bit push, input int e_err,
                           input int e_ff, input int e_pass);
    exp_t e;
    @(negedge clk);
    mode  = m;
    start = 1'b1;
    if (push) begin
      e.done_cyc = cyc + 1 + RUN_LEN;
      e.err      = e_err;
      e.ff       = e_ff;
      e.pass     = e_pass;
      sbq.push_back(e);
    end
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while ((sbq.size() != 0 || busy) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("run_finished_in_budget", int'(n < budget), 1);
  endtask

  task automatic wait_vec(input int v);
    int n = 0;
    while (!(busy && stim() == v) && n < 500) begin
      @(negedge clk);
      n++;
    end
    check("reached_vector", int'(n < 500), 1);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_busy"}, int'(busy), 0);
    check({tag, "_done"}, int'(done), 0);
    check({tag, "_pass"}, int'(pass), 0);
    check({tag, "_err_cnt"}, int'(err_cnt), 0);
    check({tag, "_first_fail"}, int'(first_fail), 0);
    check({tag, "_stim"}, stim(), 0);
  endtask

  initial begin
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_state("reset");
    rst_n = 1'b1;

    // Good cell: pass, no mismatches, done 129 cycles after accept.
    start_run(0, 1'b1, 0, 0, 1);
    wait_idle(400);

    // Stuck-at-1: vectors 25..31 expect 0.
    start_run(1, 1'b1, 7, 25, 0);
    wait_idle(400);

    // Stuck-at-0: vectors 0..24 expect 1.
    start_run(2, 1'b1, 25, 0, 0);
    wait_idle(400);

    // Abort during vector 10 of a stuck-at-0 run: counts held, no done.
    start_run(2, 1'b0, 0, 0, 0);
    wait_vec(10);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_busy", int'(busy), 0);
    check("abort_done", int'(done), 0);
    check("abort_pass", int'(pass), 0);
    check("abort_err_held", int'(err_cnt), 10);
    check("abort_ff_held", int'(first_fail), 0);
    repeat (40) @(negedge clk);
    check("abort_stays_idle", int'(busy), 0);

    // Start pulsed mid-run is ignored; done timing proves no restart.
    start_run(0, 1'b1, 0, 0, 1);
    wait_vec(5);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    begin
      int n = 0;
      while (stim() == 5 && n < 50) begin
        @(negedge clk);
        n++;
      end
    end
    check("vec_after_5", stim(), 6);
    wait_idle(400);

    // Reset during SETTLE discards the run, then a fresh run completes.
    start_run(1, 1'b0, 0, 0, 0);
    wait_vec(3);
    rst_n = 1'b0;
    @(negedge clk);
    check_reset_state("midrun_reset");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    start_run(0, 1'b1, 0, 0, 1);
    wait_idle(400);

    check("scoreboard_empty", sbq.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/scs8hd_o311ai_vector_seq.md
SCS8HD_O311AI_VECTOR_SEQ -- requirements
Module: scs8hd_o311ai_vector_seq

Interface
REQ-001 The block SHALL expose parameter SETTLE_CYCLES, default 2, meaning idle cycles between vector drive and output sample; legal range 1..15.
REQ-002 The block SHALL expose port clk, input, 1, the single clock; all state SHALL update on its rising edge.
REQ-003 The block SHALL expose port rst_n, input, 1, synchronous active-low reset.
REQ-004 The block SHALL expose port start, input, 1, run request, sampled only in IDLE.
REQ-005 The block SHALL expose port abort, input, 1, terminate the current run.
REQ-006 The block SHALL expose ports a1, a2, a3, b1, c1, output, 1 each, registered stimulus to the cell under test.
REQ-007 The block SHALL expose port y_cut, input, 1, output of the cell under test.
REQ-008 The block SHALL expose port busy, output, 1, high while a run is in progress.
REQ-009 The block SHALL expose port done, output, 1, one-cycle pulse when a run completes normally.
REQ-010 The block SHALL expose port pass, output, 1, high when the last completed run had zero mismatches.
REQ-011 The block SHALL expose port err_cnt, output, 6, mismatch count of the current or last run (0..32).
REQ-012 The block SHALL expose port first_fail, output, 5, vector index of the first mismatch; valid only when err_cnt is nonzero.

Function
REQ-013 Vector mapping SHALL be vec[0]=a1, vec[1]=a2, vec[2]=a3, vec[3]=b1, vec[4]=c1.
REQ-014 Expected output SHALL be NOT((a1 OR a2 OR a3) AND b1 AND c1).
REQ-015 The FSM SHALL have states IDLE, DRIVE, SETTLE, SAMPLE, DONE.
REQ-016 On start=1 in IDLE, the FSM SHALL enter DRIVE next cycle with vec=0, clear err_cnt, first_fail and pass, and set busy=1.
REQ-017 DRIVE SHALL last 1 cycle with stimulus registered from vec, then go to SETTLE.
REQ-018 SETTLE SHALL count exactly SETTLE_CYCLES cycles, then go to SAMPLE.
REQ-019 SAMPLE SHALL compare y_cut with the expected value in 1 cycle; on mismatch it SHALL increment err_cnt and, if err_cnt was 0, load first_fail=vec.
REQ-020 From SAMPLE, the FSM SHALL go to DONE if vec=31, else increment vec and go to DRIVE.
REQ-021 DONE SHALL last 1 cycle with done=1 and pass=(err_cnt==0) registered, then return to IDLE with busy=0.
REQ-022 Run length from the start-accept edge to the done pulse SHALL be 32*(SETTLE_CYCLES+2)+1 cycles.
REQ-023 start while not in IDLE SHALL be ignored.
REQ-024 abort in any non-IDLE state SHALL return the FSM to IDLE next cycle with busy=0, done=0, pass=0, and err_cnt/first_fail held; abort SHALL take priority over every other transition, including the final SAMPLE.
REQ-025 Stimulus outputs SHALL hold their last value in IDLE.
REQ-026 err_cnt SHALL saturate at 32; vec SHALL NOT wrap within a run.

Reset
REQ-027 When rst_n=0 at a clock edge, the block SHALL set state=IDLE, vec=0, a1..c1=0, busy=0, done=0, pass=0, err_cnt=0, first_fail=0 and the settle counter to 0.
REQ-028 Reset mid-run SHALL discard the run with no done pulse; reset SHALL take priority over abort and start.

Structure
REQ-029 Package scs8hd_cut_pkg SHALL hold the FSM state enum, VEC_W=5, NUM_VEC=32 and ERR_W=6.
REQ-030 The expected function SHALL be a sub-module scs8hd_o311ai_golden (5 inputs to 1 output, combinational), instantiated once.

Verification
REQ-031 Bench SHALL check: correct cell model, SETTLE_CYCLES=2 -> done at cycle 129 after the start-accept edge, pass=1, err_cnt=0.
REQ-032 Bench SHALL check: y_cut stuck-at-1 -> err_cnt=7, first_fail=25, pass=0.
REQ-033 Bench SHALL check: y_cut stuck-at-0 -> err_cnt=25, first_fail=0, pass=0.
REQ-034 Bench SHALL check: abort during vector 10 -> busy=0 next cycle, no done pulse, pass=0.
REQ-035 Bench SHALL check: start pulsed at vector 5 -> no restart and vec continues to 6.
REQ-036 Bench SHALL check: rst_n=0 during SETTLE -> all outputs at reset values next edge, then a fresh start completes normally.
